// File: rtl/data_mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_arb_pkg
// Shared definitions for the data-memory arbiter:
//   arb_state_t  - sequencing states of the arbiter FSM
//   PORT_IF      - owner index of the instruction-fetch port
//   PORT_LS      - owner index of the load/store port
//   ALIGN_MASK   - byte-offset bits that must be zero for a 64-bit access
// ---------------------------------------------------------------------------
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

  localparam logic [2:0] ALIGN_MASK = 3'b111;

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-request round-robin grant logic, purely combinational. The priority
// register lives in the parent; this block only resolves one cycle's grant.
//   req  [1:0] in  request vector (bit 0 = fetch, bit 1 = load/store)
//   prio       in  port index preferred when both request
//   gnt  [1:0] out one-hot grant, or zero when nobody requests
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  // A sole requester always wins; prio only breaks a tie.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = prio ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
// Shares one single-port synchronous 64-bit data memory between the
// instruction-fetch port (read-only) and the load/store port. One request is
// in flight at a time; the memory strobe lasts exactly one cycle and the read
// data is captured the cycle after it.
//   clk, reset            clock and asynchronous active-low reset
//   if_req_*  / if_rsp_*  fetch request / response handshakes
//   ls_req_*  / ls_rsp_*  load/store request / response handshakes
//   mem_addr, mem_wdata   word index and write data to the memory
//   mem_read, mem_write   one-cycle strobes, never both high
//   mem_rdata             read data, valid the cycle after mem_read
// ---------------------------------------------------------------------------
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int MEM_AW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  input  logic              if_rsp_ready,
  output logic [DATA_W-1:0] if_rsp_data,
  output logic              if_rsp_err,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [ADDR_W-1:0] ls_req_addr,
  input  logic              ls_req_we,
  input  logic [DATA_W-1:0] ls_req_wdata,
  output logic              ls_rsp_valid,
  input  logic              ls_rsp_ready,
  output logic [DATA_W-1:0] ls_rsp_data,
  output logic              ls_rsp_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state_q;
  logic              prio_q;
  logic              owner_q;
  logic              we_q;
  logic [MEM_AW-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;

  logic [1:0]        gnt;
  logic              idle;
  logic              accept;
  logic              sel_ls;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic              misaligned;
  logic              rsp_done;
  logic              addr_hi_unused;

  rr_arb2 u_rr_arb2 (
    .req  ({ls_req_valid, if_req_valid}),
    .prio (prio_q),
    .gnt  (gnt)
  );

  // Request side: the winner is chosen and accepted in the same IDLE cycle.
  assign idle       = (state_q == IDLE);
  assign accept     = idle && (gnt != 2'b00);
  assign sel_ls     = gnt[1];
  assign sel_addr   = sel_ls ? ls_req_addr : if_req_addr;
  assign sel_we     = sel_ls && ls_req_we;
  assign misaligned = |(sel_addr[2:0] & ALIGN_MASK);

  // Address bits above the memory's word range are intentionally ignored.
  assign addr_hi_unused = ^sel_addr[ADDR_W-1:MEM_AW+3];

  // Ready is also gated by reset so no handshake can complete while held.
  assign if_req_ready = reset && idle && gnt[0];
  assign ls_req_ready = reset && idle && gnt[1];

  assign rsp_done = (state_q == RESP) &&
                    ((owner_q == PORT_LS) ? ls_rsp_ready : if_rsp_ready);

  // Sequencing FSM. The response register is cleared on accept so stores and
  // misaligned requests return zero data; only CAPTURE loads memory data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      prio_q     <= PORT_IF;
      owner_q    <= PORT_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            owner_q    <= sel_ls;
            addr_q     <= sel_addr[MEM_AW+2:3];
            we_q       <= sel_we;
            wdata_q    <= sel_we ? ls_req_wdata : '0;
            rsp_data_q <= '0;
            rsp_err_q  <= misaligned;
            state_q    <= misaligned ? RESP : ACCESS;
          end
        end
        ACCESS: begin
          state_q <= we_q ? RESP : CAPTURE;
        end
        CAPTURE: begin
          rsp_data_q <= mem_rdata;
          state_q    <= RESP;
        end
        RESP: begin
          if (rsp_done) begin
            state_q <= IDLE;
            prio_q  <= ~owner_q;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Strobes come straight from state so they fall the instant reset asserts.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_read  = (state_q == ACCESS) && !we_q;
  assign mem_write = (state_q == ACCESS) && we_q;

  // Only the owning port sees its response; the other port stays quiet.
  assign if_rsp_valid = (state_q == RESP) && (owner_q == PORT_IF);
  assign ls_rsp_valid = (state_q == RESP) && (owner_q == PORT_LS);
  assign if_rsp_data  = if_rsp_valid ? rsp_data_q : '0;
  assign ls_rsp_data  = ls_rsp_valid ? rsp_data_q : '0;
  assign if_rsp_err   = if_rsp_valid && rsp_err_q;
  assign ls_rsp_err   = ls_rsp_valid && rsp_err_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_mem_arbiter
// Self-checking bench for data_mem_arbiter: a table of single-port vectors,
// hand-written multi-cycle sequences (alternation, stalled response, reset
// during a store) and a randomized run against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_data_mem_arbiter;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int MEM_AW = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req_valid, if_req_ready;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_rsp_valid, if_rsp_ready;
  logic [DATA_W-1:0] if_rsp_data;
  logic              if_rsp_err;
  logic              ls_req_valid, ls_req_ready;
  logic [ADDR_W-1:0] ls_req_addr;
  logic              ls_req_we;
  logic [DATA_W-1:0] ls_req_wdata;
  logic              ls_rsp_valid, ls_rsp_ready;
  logic [DATA_W-1:0] ls_rsp_data;
  logic              ls_rsp_err;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read, mem_write;
  logic [DATA_W-1:0] mem_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready),
    .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
    .ls_req_we(ls_req_we), .ls_req_wdata(ls_req_wdata),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_ready(ls_rsp_ready),
    .ls_rsp_data(ls_rsp_data), .ls_rsp_err(ls_rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  // Power-on contents of the memory, with a few words preloaded for tests.
  function automatic logic [63:0] initWord(input int i);
    case (i)
      8:       return 64'hDEADBEEF_00000001;
      4:       return 64'h0000_1111_2222_3333;
      3:       return 64'h0000_0000_0000_3333;
      default: return {16'h5A5A, i[15:0], 16'hC0DE, i[15:0]};
    endcase
  endfunction

  // Behavioural single-port memory with one-cycle registered read.
  logic [63:0] mem_array [0:65535];
  bit          mem_written [0:65535];

  function automatic logic [63:0] memWord(input int i);
    return mem_written[i] ? mem_array[i] : initWord(i);
  endfunction

  always @(posedge clk) begin
    if (mem_write) begin
      mem_array[int'(mem_addr)]   <= mem_wdata;
      mem_written[int'(mem_addr)] <= 1'b1;
    end
    if (mem_read) begin
      mem_rdata <= memWord(int'(mem_addr));
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " if_req_ready"}, if_req_ready, 0);
    checkOutput({tag, " ls_req_ready"}, ls_req_ready, 0);
    checkOutput({tag, " if_rsp_valid"}, if_rsp_valid, 0);
    checkOutput({tag, " ls_rsp_valid"}, ls_rsp_valid, 0);
    checkOutput({tag, " if_rsp_err"}, if_rsp_err, 0);
    checkOutput({tag, " ls_rsp_err"}, ls_rsp_err, 0);
    checkOutput({tag, " if_rsp_data"}, if_rsp_data, 0);
    checkOutput({tag, " ls_rsp_data"}, ls_rsp_data, 0);
    checkOutput({tag, " mem_read"}, mem_read, 0);
    checkOutput({tag, " mem_write"}, mem_write, 0);
    checkOutput({tag, " mem_addr"}, 64'(mem_addr), 0);
    checkOutput({tag, " mem_wdata"}, mem_wdata, 0);
  endtask

  task automatic clearInputs();
    if_req_valid = 0; if_req_addr = '0; if_rsp_ready = 0;
    ls_req_valid = 0; ls_req_addr = '0; ls_req_we = 0; ls_req_wdata = '0; ls_rsp_ready = 0;
  endtask

  task automatic resetDut();
    @(negedge clk);
    clearInputs();
    reset = 0;
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  task automatic drainResponses();
    @(posedge clk); #1;
    if_req_valid = 0; ls_req_valid = 0;
    if_rsp_ready = 1; ls_rsp_ready = 1;
    repeat (6) @(posedge clk);
  endtask

  typedef struct {
    string       name;
    logic        is_ls;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  // One request on one port with response ready high; checks acceptance,
  // strobe count and address, response latency, data and error flag.
  task automatic applyStimulus(input vec_t v);
    int n, lat, reads, writes;
    logic [63:0] s_addr, s_wdata;
    logic got_valid, got_err;
    logic [63:0] got_data;
    @(posedge clk); #1;
    if (v.is_ls) begin
      ls_req_valid = 1; ls_req_addr = v.addr; ls_req_we = v.we; ls_req_wdata = v.wdata;
    end else begin
      if_req_valid = 1; if_req_addr = v.addr;
    end
    if_rsp_ready = 1; ls_rsp_ready = 1;
    n = 0;
    @(negedge clk);
    while (!(v.is_ls ? ls_req_ready : if_req_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({v.name, " accepted"}, v.is_ls ? ls_req_ready : if_req_ready, 1);
    @(posedge clk); #1;
    if_req_valid = 0; ls_req_valid = 0; ls_req_we = 0;
    lat = 0; reads = 0; writes = 0; s_addr = '0; s_wdata = '0; got_valid = 0;
    while (!got_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (mem_read)  begin reads++;  s_addr = 64'(mem_addr); end
      if (mem_write) begin writes++; s_addr = 64'(mem_addr); s_wdata = mem_wdata; end
      got_valid = v.is_ls ? ls_rsp_valid : if_rsp_valid;
    end
    got_data = v.is_ls ? ls_rsp_data : if_rsp_data;
    got_err  = v.is_ls ? ls_rsp_err : if_rsp_err;
    checkOutput({v.name, " rsp_valid"}, got_valid, 1);
    checkOutput({v.name, " latency"}, 64'(lat), 64'(v.exp_lat));
    checkOutput({v.name, " data"}, got_data, v.exp_data);
    checkOutput({v.name, " err"}, got_err, v.exp_err);
    checkOutput({v.name, " read strobes"}, 64'(reads), (!v.exp_err && !v.we) ? 64'd1 : 64'd0);
    checkOutput({v.name, " write strobes"}, 64'(writes), (!v.exp_err && v.we) ? 64'd1 : 64'd0);
    if (!v.exp_err) checkOutput({v.name, " mem_addr"}, s_addr, 64'(v.addr[18:3]));
    if (!v.exp_err && v.we) checkOutput({v.name, " mem_wdata"}, s_wdata, v.wdata);
    @(posedge clk);
  endtask

  function automatic logic [63:0] randAddr();
    logic [63:0] hi;
    logic [63:0] idx;
    logic [63:0] low;
    hi  = {$urandom, $urandom};
    idx = 64'($urandom_range(0, 15));
    low = ($urandom_range(0, 7) == 0) ? 64'($urandom_range(1, 7)) : 64'd0;
    return (hi & 64'hFFFF_FFFF_FFF8_0000) | (idx << 3) | low;
  endfunction

  // Reference model storage (transaction-level view of memory contents).
  logic [63:0] ref_mem [int];

  function automatic logic [63:0] refWord(input int i);
    return ref_mem.exists(i) ? ref_mem[i] : initWord(i);
  endfunction

  initial begin
    vec_t vecs[8];
    int   order[8];
    int   gcyc[8];
    int   grants, cyc, n;
    logic [63:0] held_data;

    vecs[0] = '{"fetch 0x40",      0, 0, 64'h40, 64'h0, 64'hDEADBEEF_00000001, 0, 3};
    vecs[1] = '{"store 0x10",      1, 1, 64'h10, 64'h1234, 64'h0, 0, 2};
    vecs[2] = '{"load 0x10",       1, 0, 64'h10, 64'h0, 64'h1234, 0, 3};
    vecs[3] = '{"load 0x13",       1, 0, 64'h13, 64'h0, 64'h0, 1, 1};
    vecs[4] = '{"store 0x21",      1, 1, 64'h21, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, 1};
    vecs[5] = '{"load 0x20",       1, 0, 64'h20, 64'h0, 64'h0000_1111_2222_3333, 0, 3};
    vecs[6] = '{"fetch hi bits",   0, 0, 64'hFFFF_0000_0000_0048, 64'h0, 64'h5A5A_0009_C0DE_0009, 0, 3};
    vecs[7] = '{"fetch 0x44",      0, 0, 64'h44, 64'h0, 64'h0, 1, 1};

    clearInputs();
    reset = 0;
    $display("[TB] reset phase");
    repeat (2) @(negedge clk);
    if_req_valid = 1; ls_req_valid = 1; if_req_addr = 64'h40; ls_req_addr = 64'h10;
    @(negedge clk);
    checkResetValues("reset");
    clearInputs();
    reset = 1;

    $display("[TB] vector table");
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    $display("[TB] round-robin alternation");
    resetDut();
    @(posedge clk); #1;
    if_req_valid = 1; if_req_addr = 64'h40;
    ls_req_valid = 1; ls_req_addr = 64'h10; ls_req_we = 0;
    if_rsp_ready = 1; ls_rsp_ready = 1;
    grants = 0; cyc = 0;
    while (grants < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      checkOutput("exclusive ready", 64'(if_req_ready & ls_req_ready), 0);
      if (if_req_ready || ls_req_ready) begin
        order[grants] = ls_req_ready ? 1 : 0;
        gcyc[grants]  = cyc;
        grants++;
      end
    end
    checkOutput("grant count", 64'(grants), 8);
    for (int i = 0; i < grants; i++) begin
      checkOutput("grant order", 64'(order[i]), 64'(i % 2));
      if (i > 0) checkOutput("grant spacing", 64'(gcyc[i] - gcyc[i-1]), 4);
    end
    drainResponses();

    $display("[TB] stalled response");
    resetDut();
    @(posedge clk); #1;
    ls_req_valid = 1; ls_req_addr = 64'h40; ls_req_we = 0;
    if_rsp_ready = 0; ls_rsp_ready = 0;
    @(negedge clk);
    checkOutput("stall accept ls", ls_req_ready, 1);
    @(posedge clk); #1;
    ls_req_valid = 0;
    if_req_valid = 1; if_req_addr = 64'h10;
    n = 0;
    while (!ls_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
      checkOutput("stall if_req_ready busy", if_req_ready, 0);
    end
    checkOutput("stall rsp latency", 64'(n), 3);
    held_data = 64'hDEADBEEF_00000001;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("stall ls_rsp_valid", ls_rsp_valid, 1);
      checkOutput("stall ls_rsp_data", ls_rsp_data, held_data);
      checkOutput("stall ls_rsp_err", ls_rsp_err, 0);
      checkOutput("stall if_req_ready", if_req_ready, 0);
      checkOutput("stall if_rsp_valid", if_rsp_valid, 0);
    end
    @(posedge clk); #1;
    ls_rsp_ready = 1;
    @(negedge clk);
    checkOutput("stall release valid", ls_rsp_valid, 1);
    @(negedge clk);
    checkOutput("stall release done", ls_rsp_valid, 0);
    checkOutput("stall next grant if", if_req_ready, 1);
    drainResponses();

    $display("[TB] reset during store access");
    resetDut();
    @(posedge clk); #1;
    ls_req_valid = 1; ls_req_addr = 64'h18; ls_req_we = 1; ls_req_wdata = 64'hCAFE;
    ls_rsp_ready = 1;
    @(negedge clk);
    checkOutput("abort accept", ls_req_ready, 1);
    @(posedge clk); #1;
    ls_req_valid = 0; ls_req_we = 0;
    @(negedge clk);
    checkOutput("abort mem_write before", mem_write, 1);
    checkOutput("abort mem_addr before", 64'(mem_addr), 3);
    #1 reset = 0;
    #1 checkResetValues("abort");
    @(posedge clk);
    @(negedge clk);
    checkResetValues("abort held");
    reset = 1;
    checkOutput("abort memory word", memWord(3), 64'h0000_0000_0000_3333);
    applyStimulus('{"load after abort", 1, 0, 64'h18, 64'h0, 64'h0000_0000_0000_3333, 0, 3});

    $display("[TB] randomized run");
    resetDut();
    for (int i = 0; i < 16; i++) ref_mem[i] = memWord(i);
    begin
      bit          m_busy = 0, m_owner = 0, m_prio = 0, m_err = 0, m_strobe_we = 0;
      bit          acc_if = 0, acc_ls = 0, win;
      int          m_rsp_cycle = 0, m_strobe_cycle = -10, lat;
      logic [63:0] m_data = '0, m_strobe_idx = '0, m_strobe_wdata = '0, a;
      bit          we;
      bit          e_if_rdy, e_ls_rdy, e_if_rv, e_ls_rv, e_mr, e_mw;
      for (int c = 0; c < 2500; c++) begin
        @(posedge clk); #1;
        if (acc_if) if_req_valid = 0;
        if (acc_ls) begin ls_req_valid = 0; ls_req_we = 0; end
        acc_if = 0; acc_ls = 0;
        if (!if_req_valid && $urandom_range(0, 2) == 0) begin
          if_req_valid = 1; if_req_addr = randAddr();
        end
        if (!ls_req_valid && $urandom_range(0, 2) == 0) begin
          ls_req_valid = 1; ls_req_addr = randAddr();
          ls_req_we = 1'($urandom_range(0, 1)); ls_req_wdata = {$urandom, $urandom};
        end
        if_rsp_ready = ($urandom_range(0, 3) != 0);
        ls_rsp_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        e_if_rdy = 0; e_ls_rdy = 0; e_if_rv = 0; e_ls_rv = 0;
        e_mr = (c == m_strobe_cycle) && !m_strobe_we;
        e_mw = (c == m_strobe_cycle) && m_strobe_we;
        if (!m_busy) begin
          if (if_req_valid || ls_req_valid) begin
            win = (if_req_valid && ls_req_valid) ? m_prio : ls_req_valid;
            a   = win ? ls_req_addr : if_req_addr;
            we  = win && ls_req_we;
            if (win) begin e_ls_rdy = 1; acc_ls = 1; end
            else     begin e_if_rdy = 1; acc_if = 1; end
            m_err  = (a[2:0] != 3'b000);
            m_data = '0;
            if (m_err) begin
              lat = 1;
            end else begin
              m_strobe_cycle = c + 1;
              m_strobe_we    = we;
              m_strobe_idx   = 64'(a[18:3]);
              m_strobe_wdata = ls_req_wdata;
              if (we) begin
                lat = 2;
                ref_mem[int'(a[18:3])] = ls_req_wdata;
              end else begin
                lat = 3;
                m_data = refWord(int'(a[18:3]));
              end
            end
            m_busy = 1; m_owner = win; m_rsp_cycle = c + lat;
          end
        end else if (c >= m_rsp_cycle) begin
          if (m_owner) e_ls_rv = 1; else e_if_rv = 1;
        end
        checkOutput("rand if_req_ready", if_req_ready, e_if_rdy);
        checkOutput("rand ls_req_ready", ls_req_ready, e_ls_rdy);
        checkOutput("rand if_rsp_valid", if_rsp_valid, e_if_rv);
        checkOutput("rand ls_rsp_valid", ls_rsp_valid, e_ls_rv);
        checkOutput("rand mem_read", mem_read, e_mr);
        checkOutput("rand mem_write", mem_write, e_mw);
        if (e_mr || e_mw) checkOutput("rand mem_addr", 64'(mem_addr), m_strobe_idx);
        if (e_mw) checkOutput("rand mem_wdata", mem_wdata, m_strobe_wdata);
        if (e_if_rv) begin
          checkOutput("rand if_rsp_data", if_rsp_data, m_data);
          checkOutput("rand if_rsp_err", if_rsp_err, m_err);
        end
        if (e_ls_rv) begin
          checkOutput("rand ls_rsp_data", ls_rsp_data, m_data);
          checkOutput("rand ls_rsp_err", ls_rsp_err, m_err);
        end
        if (m_busy && c >= m_rsp_cycle && (m_owner ? ls_rsp_ready : if_rsp_ready)) begin
          m_busy = 0;
          m_prio = ~m_owner;
        end
      end
    end
    drainResponses();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
